peer_conflict_checker: RTL

- Decides whether candidate digit D may legally be placed in cell (R,C) of the 9x9 board.
- Scans the 27 peer cells (row, column, 3x3 box) of that cell through a synchronous board RAM read port.
- Consumes the digit/cell values produced by the solver's candidate counters.
- Returns a legal/illegal verdict to the solver control FSM through a start/done handshake.

---
 rtl/sudoku_pkg.sv | 61 ++++++
 rtl/peer_addr_gen.sv | 62 ++++++
 rtl/peer_conflict_checker.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
// Shared board geometry, FSM/phase encodings and small address helpers for
// the sudoku solver blocks.
package sudoku_pkg;

  localparam logic [3:0] GRID_SIZE   = 4'd9;
  localparam logic [3:0] BOX_SIZE    = 4'd3;
  localparam logic [6:0] CELL_COUNT  = 7'd81;
  localparam int         ADDR_WIDTH  = 7;
  localparam int         DIGIT_WIDTH = 4;
  localparam logic [3:0] EMPTY_CELL  = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_ROW = 2'd0,
    PH_COL = 2'd1,
    PH_BOX = 2'd2
  } phase_e;

  // row*9 + col as (row<<3)+row+col; callers pass row/col in 0..8.
  function automatic logic [6:0] cell_addr(input logic [3:0] row, input logic [3:0] col);
    logic [6:0] r7;
    r7 = {3'd0, row};
    return (r7 << 3) + r7 + {3'd0, col};
  endfunction

  // First row/column of the 3x3 box holding coordinate v.
  function automatic logic [3:0] box_base(input logic [3:0] v);
    if (v < BOX_SIZE) begin
      return 4'd0;
    end else if (v < (BOX_SIZE << 1)) begin
      return BOX_SIZE;
    end else begin
      return BOX_SIZE << 1;
    end
  endfunction

  // Box-local row offset of the phase index (idx / 3).
  function automatic logic [3:0] idx_div3(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: return 4'd0;
      4'd3, 4'd4, 4'd5: return 4'd1;
      default:          return 4'd2;
    endcase
  endfunction

  // Box-local column offset of the phase index (idx % 3).
  function automatic logic [3:0] idx_mod3(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: return 4'd0;
      4'd1, 4'd4, 4'd7: return 4'd1;
      default:          return 4'd2;
    endcase
  endfunction

endpackage

// File: rtl/peer_addr_gen.sv
// Walks the 27 peers of a cell: row, then column, then 3x3 box (row-major).
// The counters always point at the next peer to be read.
import sudoku_pkg::*;

module peer_addr_gen (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  clear_i,
  input  logic                  advance_i,
  input  logic [3:0]            row_i,
  input  logic [3:0]            col_i,
  output logic [ADDR_WIDTH-1:0] peer_addr_o,
  output logic                  last_peer_o
);

  localparam logic [3:0] LAST_IDX = GRID_SIZE - 4'd1;

  phase_e     phase_q;
  logic [3:0] idx_q;
  logic [3:0] box_row_s;
  logic [3:0] box_col_s;

  // Phase/index counters; index wraps 8->0 and moves to the next phase.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      phase_q <= PH_ROW;
      idx_q   <= 4'd0;
    end else if (clear_i) begin
      phase_q <= PH_ROW;
      idx_q   <= 4'd0;
    end else if (advance_i) begin
      if (idx_q == LAST_IDX) begin
        idx_q <= 4'd0;
        case (phase_q)
          PH_ROW:  phase_q <= PH_COL;
          PH_COL:  phase_q <= PH_BOX;
          default: phase_q <= PH_ROW;
        endcase
      end else begin
        idx_q <= idx_q + 4'd1;
      end
    end else begin
      phase_q <= phase_q;
      idx_q   <= idx_q;
    end
  end

  // Peer address for the current phase and index.
  always_comb begin
    box_row_s   = box_base(row_i) + idx_div3(idx_q);
    box_col_s   = box_base(col_i) + idx_mod3(idx_q);
    peer_addr_o = 7'd0;
    case (phase_q)
      PH_ROW:  peer_addr_o = cell_addr(row_i, idx_q);
      PH_COL:  peer_addr_o = cell_addr(idx_q, col_i);
      PH_BOX:  peer_addr_o = cell_addr(box_row_s, box_col_s);
      default: peer_addr_o = 7'd0;
    endcase
    last_peer_o = (phase_q == PH_BOX) && (idx_q == LAST_IDX);
  end

endmodule

// File: rtl/peer_conflict_checker.sv
// Checks whether a candidate digit may be placed in a cell by reading its 27
// peers from the board RAM and reporting the first conflicting peer.
import sudoku_pkg::*;

module peer_conflict_checker (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic [3:0]             cell_row_i,
  input  logic [3:0]             cell_col_i,
  input  logic [DIGIT_WIDTH-1:0] digit_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   legal_o,
  output logic [ADDR_WIDTH-1:0]  conflict_addr_o,
  output logic                   rd_en_o,
  output logic [ADDR_WIDTH-1:0]  rd_addr_o,
  input  logic [DIGIT_WIDTH-1:0] rd_data_i
);

  localparam logic [6:0] MAX_ADDR = CELL_COUNT - 7'd1;

  state_e                 state_q;
  logic [3:0]             row_q;
  logic [3:0]             col_q;
  logic [DIGIT_WIDTH-1:0] digit_q;
  logic [ADDR_WIDTH-1:0]  target_q;
  logic [ADDR_WIDTH-1:0]  tag_q;
  logic                   valid_q;
  logic                   all_issued_q;
  logic                   invalid_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   legal_q;
  logic [ADDR_WIDTH-1:0]  conflict_addr_q;
  logic                   rd_en_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;

  logic                   accept_s;
  logic                   req_invalid_s;
  logic                   issue_s;
  logic                   hit_s;
  logic [3:0]             row_sel_s;
  logic [3:0]             col_sel_s;
  logic [7:0]             tgt_full_s;
  logic [ADDR_WIDTH-1:0]  tgt_sat_s;
  logic [ADDR_WIDTH-1:0]  peer_addr_s;
  logic                   last_peer_s;

  // Request decode, read-issue decision and the tagged compare of returning data.
  always_comb begin
    accept_s      = (state_q == ST_IDLE) && start_i;
    req_invalid_s = (digit_i == EMPTY_CELL) || (digit_i > GRID_SIZE) ||
                    (cell_row_i >= GRID_SIZE) || (cell_col_i >= GRID_SIZE);
    // The first peer address is formed from the live inputs in the accept cycle.
    if (accept_s) begin
      row_sel_s = cell_row_i;
      col_sel_s = cell_col_i;
    end else begin
      row_sel_s = row_q;
      col_sel_s = col_q;
    end
    tgt_full_s = ({4'd0, cell_row_i} << 3) + {4'd0, cell_row_i} + {4'd0, cell_col_i};
    if (tgt_full_s > {1'b0, MAX_ADDR}) begin
      tgt_sat_s = MAX_ADDR;
    end else begin
      tgt_sat_s = tgt_full_s[6:0];
    end
    // A datum conflicts when it matches the digit and is not the target cell itself.
    hit_s   = valid_q && (rd_data_i == digit_q) && (tag_q != target_q);
    issue_s = (accept_s && !req_invalid_s) ||
              ((state_q == ST_SCAN) && !hit_s && !all_issued_q);
  end

  peer_addr_gen u_peer_addr_gen (
    .clock_i     (clock_i),
    .reset_ni    (reset_ni),
    .clear_i     (!issue_s),
    .advance_i   (issue_s),
    .row_i       (row_sel_s),
    .col_i       (col_sel_s),
    .peer_addr_o (peer_addr_s),
    .last_peer_o (last_peer_s)
  );

  // Main FSM with registered handshake, verdict and RAM read outputs.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q         <= ST_IDLE;
      row_q           <= 4'd0;
      col_q           <= 4'd0;
      digit_q         <= 4'd0;
      target_q        <= 7'd0;
      tag_q           <= 7'd0;
      valid_q         <= 1'b0;
      all_issued_q    <= 1'b0;
      invalid_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      legal_q         <= 1'b0;
      conflict_addr_q <= 7'd0;
      rd_en_q         <= 1'b0;
      rd_addr_q       <= 7'd0;
    end else begin
      // Data returns one cycle after the strobe; tag it with its address.
      valid_q <= rd_en_q;
      tag_q   <= rd_addr_q;
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            row_q        <= cell_row_i;
            col_q        <= cell_col_i;
            digit_q      <= digit_i;
            target_q     <= tgt_sat_s;
            busy_q       <= 1'b1;
            all_issued_q <= 1'b0;
            if (req_invalid_s) begin
              // Bad request: skip the scan, DRAIN delays done to cycle 2.
              invalid_q <= 1'b1;
              state_q   <= ST_DRAIN;
              rd_en_q   <= 1'b0;
            end else begin
              invalid_q <= 1'b0;
              state_q   <= ST_SCAN;
              rd_en_q   <= 1'b1;
              rd_addr_q <= peer_addr_s;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (hit_s) begin
            // Early exit; the read still in flight is never compared.
            state_q         <= ST_REPORT;
            rd_en_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b1;
            legal_q         <= 1'b0;
            conflict_addr_q <= tag_q;
          end else if (all_issued_q) begin
            state_q <= ST_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= peer_addr_s;
            if (last_peer_s) begin
              all_issued_q <= 1'b1;
            end else begin
              all_issued_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          state_q <= ST_REPORT;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (invalid_q) begin
            legal_q         <= 1'b0;
            conflict_addr_q <= target_q;
          end else if (hit_s) begin
            legal_q         <= 1'b0;
            conflict_addr_q <= tag_q;
          end else begin
            legal_q         <= 1'b1;
            conflict_addr_q <= 7'd0;
          end
        end
        ST_REPORT: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign legal_o         = legal_q;
  assign conflict_addr_o = conflict_addr_q;
  assign rd_en_o         = rd_en_q;
  assign rd_addr_o       = rd_addr_q;

endmodule
